// File: rtl/axis_pixel_proc.sv
// rtl/axis_pixel_proc.sv - per-byte pixel processor on a stream with an output FIFO
//
// Purpose:
//   Accepts pixel beats on a slave stream and processes each byte lane with the
//   frame mode: pass, invert, threshold or saturating add. The mode is latched
//   on the first beat of every frame. Processed beats are queued in a circular
//   FIFO that drives the master stream.
//
// Optional feature:
//   AXIS_PIXEL_PROC_STATS_EN - when defined, beat_count and frame_count are
//   live wrapping counters. Otherwise they are tied to 0 and no counter
//   registers exist.
//
// Ports:
//   aclk, aresetn                - clock, synchronous active-low reset
//   s_axis_tdata/tstrb/tlast     - input pixels, byte qualifiers, frame end
//   s_axis_tvalid/tready         - input handshake
//   m_axis_tdata/tstrb/tlast     - processed pixels from the FIFO head
//   m_axis_tvalid/tready         - output handshake
//   cfg_mode/thresh/offset       - live configuration, sampled at frame start
//   fifo_level                   - occupied FIFO entries
//   in_frame                     - input side is inside a multi-beat frame
//   beat_count, frame_count      - accepted beats and frames

// Circular FIFO with combinational head read and an occupancy counter.
module axis_pixel_proc_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

module axis_pixel_proc #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]       s_axis_tstrb,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]       m_axis_tstrb,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  input  logic [1:0]                    cfg_mode,
  input  logic [7:0]                    cfg_thresh,
  input  logic [7:0]                    cfg_offset,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          in_frame,
  output logic [31:0]                   beat_count,
  output logic [15:0]                   frame_count
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam int EW    = DATA_WIDTH + LANES + 1;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_INVERT = 2'd1;
  localparam logic [1:0] MODE_THRESH = 2'd2;
  localparam logic [1:0] MODE_ADD    = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [7:0]      thresh_q;
  logic [7:0]      offset_q;

  logic            push;
  logic            pop;
  logic [1:0]      eff_mode;
  logic [7:0]      eff_thresh;
  logic [7:0]      eff_offset;
  logic [DATA_WIDTH-1:0] proc_data;
  logic [EW-1:0]   head_data;

  function automatic logic [7:0] proc_lane(
    input logic [1:0] mode,
    input logic [7:0] px,
    input logic [7:0] thresh,
    input logic [7:0] offset
  );
    logic [8:0] sum;
    sum = {1'b0, px} + {1'b0, offset};
    case (mode)
      MODE_PASS:   proc_lane = px;
      MODE_INVERT: proc_lane = 8'hFF - px;
      MODE_THRESH: proc_lane = (px >= thresh) ? 8'hFF : 8'h00;
      MODE_ADD:    proc_lane = sum[8] ? 8'hFF : sum[7:0];
      default:     proc_lane = px;
    endcase
  endfunction

  // Held low in reset so nothing is accepted before pointers are cleared.
  assign s_axis_tready = aresetn && (fifo_level < LW'(FIFO_DEPTH));
  assign m_axis_tvalid = aresetn && (fifo_level != '0);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready;

  // The first beat of a frame uses live cfg; later beats use the latched copy.
  assign eff_mode   = (state == ST_IDLE) ? cfg_mode   : mode_q;
  assign eff_thresh = (state == ST_IDLE) ? cfg_thresh : thresh_q;
  assign eff_offset = (state == ST_IDLE) ? cfg_offset : offset_q;

  // Strobe does not gate processing: every lane is transformed.
  always_comb begin
    proc_data = '0;
    for (int i = 0; i < LANES; i++) begin
      proc_data[i*8 +: 8] = proc_lane(eff_mode, s_axis_tdata[i*8 +: 8],
                                      eff_thresh, eff_offset);
    end
  end

  // Input-side frame tracker; in_frame is registered alongside the state.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state    <= ST_IDLE;
      in_frame <= 1'b0;
      mode_q   <= MODE_PASS;
      thresh_q <= 8'h00;
      offset_q <= 8'h00;
    end else if (push) begin
      case (state)
        ST_IDLE: begin
          mode_q   <= cfg_mode;
          thresh_q <= cfg_thresh;
          offset_q <= cfg_offset;
          if (!s_axis_tlast) begin
            state    <= ST_FRAME;
            in_frame <= 1'b1;
          end
        end
        ST_FRAME: begin
          if (s_axis_tlast) begin
            state    <= ST_IDLE;
            in_frame <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_frame <= 1'b0;
        end
      endcase
    end
  end

  axis_pixel_proc_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (push),
    .push_data ({s_axis_tlast, s_axis_tstrb, proc_data}),
    .pop       (pop),
    .head_data (head_data),
    .level     (fifo_level)
  );

  assign {m_axis_tlast, m_axis_tstrb, m_axis_tdata} = head_data;

`ifdef AXIS_PIXEL_PROC_STATS_EN
  logic [31:0] beat_cnt_q;
  logic [15:0] frame_cnt_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else if (push) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
      if (s_axis_tlast) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign beat_count  = beat_cnt_q;
  assign frame_count = frame_cnt_q;
`else
  assign beat_count  = '0;
  assign frame_count = '0;
`endif

endmodule

// File: doc/axis_pixel_proc.md
AXIS_PIXEL_PROC -- requirements
Module: axis_pixel_proc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream data width in bits; legal values are multiples of 8, minimum 8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, number of output FIFO entries; legal values are powers of 2, minimum 2.
REQ-003 SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-004 SHALL have these clock and reset ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
REQ-005 SHALL have these slave-stream ports:
- s_axis_tdata  in  DATA_WIDTH  input pixels, one byte per pixel lane
- s_axis_tstrb  in  DATA_WIDTH/8  byte qualifiers
- s_axis_tlast  in  1  last beat of frame
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
REQ-006 SHALL have these master-stream ports:
- m_axis_tdata  out  DATA_WIDTH  processed pixels
- m_axis_tstrb  out  DATA_WIDTH/8  byte qualifiers
- m_axis_tlast  out  1  last beat of frame
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
REQ-007 SHALL have these configuration ports:
- cfg_mode  in  2  0 pass, 1 invert, 2 threshold, 3 saturating add
- cfg_thresh  in  8  threshold value
- cfg_offset  in  8  brightness offset
REQ-008 SHALL have these status ports:
- fifo_level  out  clog2(FIFO_DEPTH)+1  occupied FIFO entries
- in_frame  out  1  a frame is in progress on the input side
- beat_count  out  32  accepted input beats
- frame_count  out  16  accepted input frames

Function
REQ-009 SHALL accept an input beat only on a cycle where s_axis_tvalid and s_axis_tready are both 1.
REQ-010 s_axis_tready SHALL be 1 exactly when fifo_level < FIFO_DEPTH; it SHALL not depend combinationally on m_axis_tready.
REQ-011 SHALL process each byte lane independently using the frame mode:
- pass: out = in
- invert: out = 255 - in
- threshold: out = (in >= cfg_thresh) ? 255 : 0
- add: out = min(in + cfg_offset, 255); the sum SHALL be computed 9 bits wide.
REQ-012 SHALL pass tstrb and tlast through unchanged; bytes with strobe 0 SHALL still be processed.
REQ-013 SHALL run an input-side state machine with two states:
- IDLE -> FRAME on an accepted beat with tlast = 0.
- FRAME -> IDLE on an accepted beat with tlast = 1.
- A single-beat frame (tlast = 1 in IDLE) SHALL stay in IDLE.
- in_frame = 1 exactly in FRAME.
REQ-014 SHALL capture cfg_mode, cfg_thresh and cfg_offset into the frame mode on the first accepted beat of each frame (accepted in IDLE); that beat SHALL use the live cfg values; later beats of the frame SHALL use the captured values even if cfg changes.
REQ-015 SHALL write processed beats into a FIFO_DEPTH-entry circular FIFO with read and write pointers that wrap modulo FIFO_DEPTH.
REQ-016 SHALL drive m_axis_* from the FIFO head: m_axis_tvalid = (fifo_level != 0), and m_axis_tdata/tstrb/tlast SHALL hold stable while tvalid = 1 and tready = 0.
REQ-017 Latency: a beat accepted in cycle N into an empty FIFO SHALL appear with m_axis_tvalid = 1 in cycle N+1.
REQ-018 On a simultaneous push and pop, fifo_level SHALL remain unchanged and ordering SHALL be preserved.
REQ-019 When the FIFO is full and a pop occurs, s_axis_tready SHALL return to 1 in the next cycle; a full FIFO SHALL never be overwritten.
REQ-020 Throughput SHALL be one beat per cycle when m_axis_tready is held at 1.

Reset
REQ-021 On aclk rising edge with aresetn = 0, SHALL clear:
- pointers and fifo_level to 0
- state to IDLE
- the frame mode to pass, with thresh = 0 and offset = 0
- beat_count and frame_count to 0
REQ-022 During reset, SHALL drive s_axis_tready = 0 and m_axis_tvalid = 0; in the first cycle after release, s_axis_tready SHALL be 1.
REQ-023 A reset mid-frame SHALL discard all buffered beats; the next accepted beat SHALL start a new frame.

Configuration
REQ-024 With macro AXIS_PIXEL_PROC_STATS_EN defined, SHALL implement the counters as follows:
- beat_count increments by 1 per accepted beat.
- frame_count increments by 1 per accepted tlast beat.
- Both wrap at their maximum value.
REQ-025 Without AXIS_PIXEL_PROC_STATS_EN, beat_count and frame_count SHALL be constant 0 and no counter registers SHALL be synthesised; all other behaviour SHALL be identical.

Verification
REQ-026 Mode 1, input 0x00FF10F0, tlast = 1, m_axis_tready = 1 -> 0xFF00EF0F with tlast = 1 one cycle after acceptance.
REQ-027 Mode 3, offset 0x20, input 0xF0E01000 -> 0xFFFF3020, showing saturation in the upper two lanes.
REQ-028 Mode 2, thresh 0x80, 4-beat frame; cfg_mode changed to 0 after beat 1 -> all 4 beats thresholded; the next frame is pass-through.
REQ-029 m_axis_tready = 0, push 16 beats (FIFO_DEPTH = 16) -> fifo_level = 16, s_axis_tready = 0, no data loss; one pop -> s_axis_tready = 1 next cycle, and the 17th beat is accepted in order.
REQ-030 Continuous valid/ready for 64 beats with random backpressure -> output sequence equals reference model output; with STATS_EN, 8-beat frames give beat_count = 64 and frame_count = 8.
REQ-031 aresetn asserted mid-frame with FIFO holding 5 beats -> fifo_level = 0, m_axis_tvalid = 0, in_frame = 0 and counters = 0 after the reset cycle.
